// File: rtl/anton_neopixel_apb_bridge_if.sv
// anton_neopixel_apb_bridge_if
//   Bundles the APB3 slave signals and the neopixel byte-bus signals that the
//   bridge sits between.
//   slave  modport: used by the bridge (APB inputs, byte-bus outputs).
//   master modport: used by whatever drives APB and models the neopixel bus.
interface anton_neopixel_apb_bridge_if;
    logic [15:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [13:0] busAddr;
    logic [7:0]  busDataIn;
    logic        busWrite;
    logic        busRead;
    logic [7:0]  busDataOut;

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, busDataOut,
        output PRDATA, PREADY, PSLVERR, busAddr, busDataIn, busWrite, busRead
    );

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, busDataOut,
        input  PRDATA, PREADY, PSLVERR, busAddr, busDataIn, busWrite, busRead
    );
endinterface

// File: rtl/anton_neopixel_apb_bridge.sv
// anton_neopixel_apb_bridge
//   APB3 slave that turns each 32-bit word access into four little-endian
//   byte cycles on the neopixel module's byte-wide register/pixel bus.
//   Ports:
//     busClk    - bridge, APB and byte-bus clock
//     busReset  - asynchronous, active-high reset
//     bus       - slave side of anton_neopixel_apb_bridge_if (APB3 + byte bus)
//   Parameters:
//     READ_LATENCY - cycles from busRead to valid busDataOut (1..3)
//     ADDR_LIMIT   - first illegal byte address; such accesses get PSLVERR
//   Every output is a flop; the next-state block computes next output values.
module anton_neopixel_apb_bridge #(
    parameter int          READ_LATENCY = 1,
    parameter logic [15:0] ADDR_LIMIT   = 16'h4000
) (
    input  logic                          busClk,
    input  logic                          busReset,
    anton_neopixel_apb_bridge_if.slave    bus
);
    localparam logic [2:0] RL = 3'(READ_LATENCY);

    typedef enum logic [2:0] {IDLE, ERR, WR, RD, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  lane, lane_nxt;       // lane currently driven on the byte bus
    logic [2:0]  rd_cnt, rd_cnt_nxt;   // cycles since the lane-0 read strobe
    logic [13:2] word, word_nxt;
    logic [31:0] wdata, wdata_nxt;
    logic [23:0] rbuf, rbuf_nxt;       // bytes 0..2, shifted in from the top
    logic [31:0] prdata, prdata_nxt;
    logic        pready, pready_nxt;
    logic        pslverr, pslverr_nxt;
    logic [13:0] addr, addr_nxt;
    logic [7:0]  din, din_nxt;
    logic        wr, wr_nxt;
    logic        rd, rd_nxt;

    logic [1:0]  lane_inc;
    logic [2:0]  cap;                  // byte index due at the end of this cycle

    assign lane_inc = lane + 2'd1;
    assign cap      = rd_cnt - RL;

    always_comb begin
        state_nxt   = state;
        lane_nxt    = lane;
        rd_cnt_nxt  = rd_cnt;
        word_nxt    = word;
        wdata_nxt   = wdata;
        rbuf_nxt    = rbuf;
        prdata_nxt  = prdata;
        pready_nxt  = 1'b0;
        pslverr_nxt = 1'b0;
        addr_nxt    = addr;
        din_nxt     = din;
        wr_nxt      = 1'b0;
        rd_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    word_nxt   = bus.PADDR[13:2];
                    wdata_nxt  = bus.PWDATA;
                    lane_nxt   = 2'd0;
                    rd_cnt_nxt = 3'd0;
                    if ((bus.PADDR & 16'hFFFC) >= ADDR_LIMIT) begin
                        state_nxt = ERR;
                    end else begin
                        // lane 0 goes out in the very first access-phase cycle
                        addr_nxt = {bus.PADDR[13:2], 2'd0};
                        if (bus.PWRITE) begin
                            state_nxt = WR;
                            wr_nxt    = 1'b1;
                            din_nxt   = bus.PWDATA[7:0];
                        end else begin
                            state_nxt = RD;
                            rd_nxt    = 1'b1;
                        end
                    end
                end
            end
            ERR: begin
                state_nxt   = DONE;
                pready_nxt  = 1'b1;
                pslverr_nxt = 1'b1;
                prdata_nxt  = 32'd0;
            end
            WR: begin
                if (lane == 2'd3) begin
                    state_nxt  = DONE;
                    pready_nxt = 1'b1;
                end else begin
                    lane_nxt = lane_inc;
                    wr_nxt   = 1'b1;
                    addr_nxt = {word, lane_inc};
                    din_nxt  = wdata[{lane_inc, 3'b000} +: 8];
                end
            end
            RD: begin
                rd_cnt_nxt = rd_cnt + 3'd1;
                if (lane != 2'd3) begin
                    lane_nxt = lane_inc;
                    rd_nxt   = 1'b1;
                    addr_nxt = {word, lane_inc};
                end
                // strobes and captures overlap; bytes arrive in lane order
                if (rd_cnt >= RL) begin
                    if (cap == 3'd3) begin
                        prdata_nxt = {bus.busDataOut, rbuf};
                        state_nxt  = DONE;
                        pready_nxt = 1'b1;
                    end else begin
                        rbuf_nxt = {bus.busDataOut, rbuf[23:8]};
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge busClk or posedge busReset) begin
        if (busReset) begin
            state   <= IDLE;
            lane    <= 2'd0;
            rd_cnt  <= 3'd0;
            word    <= '0;
            wdata   <= '0;
            rbuf    <= '0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            addr    <= '0;
            din     <= '0;
            wr      <= 1'b0;
            rd      <= 1'b0;
        end else begin
            state   <= state_nxt;
            lane    <= lane_nxt;
            rd_cnt  <= rd_cnt_nxt;
            word    <= word_nxt;
            wdata   <= wdata_nxt;
            rbuf    <= rbuf_nxt;
            prdata  <= prdata_nxt;
            pready  <= pready_nxt;
            pslverr <= pslverr_nxt;
            addr    <= addr_nxt;
            din     <= din_nxt;
            wr      <= wr_nxt;
            rd      <= rd_nxt;
        end
    end

    assign bus.PRDATA    = prdata;
    assign bus.PREADY    = pready;
    assign bus.PSLVERR   = pslverr;
    assign bus.busAddr   = addr;
    assign bus.busDataIn = din;
    assign bus.busWrite  = wr;
    assign bus.busRead   = rd;
endmodule

// File: tb/tb_anton_neopixel_apb_bridge.sv
// tb_anton_neopixel_apb_bridge
//   Drives the same APB stimulus into two bridges (READ_LATENCY 1 and 3), each
//   attached to its own behavioural neopixel byte memory, and compares every
//   completion and byte strobe against a word-level reference model.
module tb_anton_neopixel_apb_bridge;
    logic busClk = 1'b0;
    logic busReset;
    always #5 busClk = ~busClk;

    anton_neopixel_apb_bridge_if b1();
    anton_neopixel_apb_bridge_if b3();

    logic [15:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;

    assign b1.PADDR = paddr;   assign b3.PADDR = paddr;
    assign b1.PSEL = psel;     assign b3.PSEL = psel;
    assign b1.PENABLE = penable; assign b3.PENABLE = penable;
    assign b1.PWRITE = pwrite; assign b3.PWRITE = pwrite;
    assign b1.PWDATA = pwdata; assign b3.PWDATA = pwdata;

    anton_neopixel_apb_bridge #(.READ_LATENCY(1)) dut1 (.busClk(busClk), .busReset(busReset), .bus(b1));
    anton_neopixel_apb_bridge #(.READ_LATENCY(3)) dut3 (.busClk(busClk), .busReset(busReset), .bus(b3));

    // observed outputs, index 0 = latency 1, index 1 = latency 3
    logic        o_wr[2], o_rd[2], o_rdy[2], o_err[2];
    logic [13:0] o_addr[2];
    logic [7:0]  o_din[2];
    logic [31:0] o_prdata[2];
    assign o_wr[0] = b1.busWrite;   assign o_wr[1] = b3.busWrite;
    assign o_rd[0] = b1.busRead;    assign o_rd[1] = b3.busRead;
    assign o_rdy[0] = b1.PREADY;    assign o_rdy[1] = b3.PREADY;
    assign o_err[0] = b1.PSLVERR;   assign o_err[1] = b3.PSLVERR;
    assign o_addr[0] = b1.busAddr;  assign o_addr[1] = b3.busAddr;
    assign o_din[0] = b1.busDataIn; assign o_din[1] = b3.busDataIn;
    assign o_prdata[0] = b1.PRDATA; assign o_prdata[1] = b3.PRDATA;

    localparam int LAT[2] = '{1, 3};

    function automatic logic [7:0] init_byte(input int a);
        return 8'(a * 7 + 3);
    endfunction

    // ---------------- neopixel byte-bus model + monitor ----------------
    typedef struct {
        int          k;
        int          cyc;
        bit          wr;
        logic [13:0] a;
        logic [7:0]  d;
    } strobe_t;

    logic [7:0] mem [2][16384];
    logic [7:0] pipe [2][4];
    bit         inited = 1'b0;
    strobe_t    slog[$];
    int         cyc = 0;
    int         rdy_cnt[2] = '{0, 0};
    int         rdy_cyc[2] = '{0, 0};
    int         overlap[2] = '{0, 0};
    logic [31:0] rdy_data[2];
    logic        rdy_err[2];

    // pipe[k][i] holds the byte answered to a read strobe i cycles ago
    assign b1.busDataOut = pipe[0][1];
    assign b3.busDataOut = pipe[1][3];

    always @(posedge busClk) cyc <= cyc + 1;

    always @(negedge busClk) begin
        if (!inited) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 16384; i++)
                    mem[k][i] <= init_byte(i);
            inited <= 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            if (o_wr[k] && o_rd[k]) overlap[k] <= overlap[k] + 1;
            if (o_wr[k]) mem[k][o_addr[k]] <= o_din[k];
            if (o_wr[k] || o_rd[k])
                slog.push_back('{k: k, cyc: cyc, wr: o_wr[k], a: o_addr[k], d: o_din[k]});
            pipe[k][0] <= o_rd[k] ? mem[k][o_addr[k]] : 8'($urandom);
            for (int i = 1; i < 4; i++) pipe[k][i] <= pipe[k][i-1];
            if (o_rdy[k]) begin
                rdy_cnt[k]  <= rdy_cnt[k] + 1;
                rdy_cyc[k]  <= cyc;
                rdy_data[k] <= o_prdata[k];
                rdy_err[k]  <= o_err[k];
            end
        end
    end

    // ---------------- reference model and checking ----------------
    logic [7:0]  ref_mem [int];
    logic [31:0] exp_prdata;
    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [7:0] ref_byte(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        logic [31:0] v;
        for (int k = 0; k < 2; k++) begin
            v = o_prdata[k] | 32'(o_addr[k]) | 32'(o_din[k])
              | 32'({o_wr[k], o_rd[k], o_rdy[k], o_err[k]});
            chk(tag, v, 32'd0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge busClk); #1; end
    endtask

    // one APB transfer; entered and left 1 time unit after a rising edge
    task automatic xfer(input bit w, input logic [15:0] a, input logic [31:0] d);
        int t0, s0, s1, s_log, ba, j;
        bit err;
        logic [31:0] rv;
        paddr = a; pwrite = w; pwdata = d; psel = 1'b1; penable = 1'b0;
        t0 = cyc; s0 = rdy_cnt[0]; s1 = rdy_cnt[1]; s_log = slog.size();
        @(posedge busClk); #1;
        penable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (rdy_cnt[0] > s0 && rdy_cnt[1] > s1) break;
            @(posedge busClk); #1;
        end
        psel = 1'b0; penable = 1'b0;

        err = (a >= 16'h4000);
        ba  = int'({a[13:2], 2'b00});
        for (int n = 0; n < 4; n++) rv[8*n +: 8] = ref_byte(ba + n);
        if (err)     exp_prdata = 32'd0;
        else if (!w) exp_prdata = rv;

        for (int k = 0; k < 2; k++) begin
            chk("pready_pulses", rdy_cnt[k] - (k == 0 ? s0 : s1), 1);
            chk("pready_cycle", rdy_cyc[k] - t0, err ? 2 : (w ? 5 : 5 + LAT[k]));
            chk("pslverr", 32'(rdy_err[k]), 32'(err));
            chk("prdata", rdy_data[k], exp_prdata);
            j = 0;
            for (int q = s_log; q < slog.size(); q++) begin
                if (slog[q].k == k) begin
                    if (j < 4) begin
                        chk("strobe_cycle", slog[q].cyc - t0, j + 1);
                        chk("strobe_kind", 32'(slog[q].wr), 32'(w));
                        chk("strobe_addr", 32'(slog[q].a), 32'(ba + j));
                        if (w) chk("strobe_data", 32'(slog[q].d), 32'(d[8*j +: 8]));
                    end
                    j++;
                end
            end
            chk("strobe_count", j, err ? 0 : 4);
        end
        if (w && !err)
            for (int n = 0; n < 4; n++) ref_mem[ba + n] = d[8*n +: 8];
    endtask

    initial begin
        int s_log, cnt;
        logic [15:0] a;
        logic [31:0] d;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        exp_prdata = 32'd0;

        // reset held for three cycles
        busReset = 1'b1;
        repeat (3) @(posedge busClk);
        #1 chk_zero("reset_outputs");
        busReset = 1'b0;
        s_log = slog.size();
        idle(3);
        chk_zero("post_reset_outputs");
        chk("post_reset_strobes", slog.size() - s_log, 0);

        // directed cases
        xfer(1'b1, 16'h0010, 32'hA1B2C3D4);  idle(1);
        xfer(1'b1, 16'h0020, 32'h44332211);  idle(1);
        xfer(1'b0, 16'h0020, 32'h0);         idle(1);
        chk("read_0x20", exp_prdata, 32'h44332211);
        xfer(1'b1, 16'h4000, 32'hDEADBEEF);  idle(1);
        xfer(1'b0, 16'hFFFC, 32'h0);         idle(2);
        xfer(1'b1, 16'h3FFC, 32'h0BADF00D);  idle(1);
        xfer(1'b0, 16'h3FFE, 32'h0);
        // back-to-back write then read
        xfer(1'b1, 16'h0040, 32'hCAFEF00D);
        xfer(1'b0, 16'h0040, 32'h0);

        // randomized traffic in a small window so reads hit prior writes
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0)
                a = 16'h4000 + 16'($urandom_range(0, 16'hBFFF));
            else
                a = 16'($urandom_range(0, 63));
            d = $urandom;
            xfer(1'($urandom_range(0, 1)), a, d);
            idle($urandom_range(0, 2));
        end

        // reset while lane 2 of a write is on the bus
        d = 32'h87654321;
        paddr = 16'h0080; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        s_log = slog.size();
        @(posedge busClk); #1 penable = 1'b1;
        @(posedge busClk); #1;
        @(posedge busClk); #1;
        chk("lane2_write_strobe", 32'(o_wr[0]), 32'd1);
        chk("lane2_addr", 32'(o_addr[0]), 32'h82);
        #2 busReset = 1'b1;
        #1 chk_zero("reset_mid_write");
        psel = 1'b0; penable = 1'b0;
        @(posedge busClk); #1 busReset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cnt = 0;
            for (int q = s_log; q < slog.size(); q++) if (slog[q].k == k) cnt++;
            chk("aborted_write_bytes", cnt, 2);
        end
        ref_mem[16'h80] = d[7:0];
        ref_mem[16'h81] = d[15:8];
        exp_prdata = 32'd0;
        idle(1);
        xfer(1'b0, 16'h0080, 32'h0);
        idle(1);
        xfer(1'b1, 16'h0084, 32'h13579BDF);
        xfer(1'b0, 16'h0084, 32'h0);
        idle(2);

        chk("strobe_overlap", overlap[0] + overlap[1], 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
